// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous value update,
// leading-zero blanking and global blank. Optional blink feature under SEG_BLINK_EN.
module seven_segment_scan #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int LZB       = 0,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic                  load_i,
  input  logic                  blank_i,
  output logic [6:0]            seg_o,
  output logic [N_DIGITS-1:0]   dig_o,
  output logic                  frame_o,
  output logic                  pending_o
`ifdef SEG_BLINK_EN
  ,
  input  logic [N_DIGITS-1:0]   blink_mask_i
`endif
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int VW = 4 * N_DIGITS;

  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic [VW-1:0] r_active;
  logic [VW-1:0] r_hold;

  logic       w_tick;
  logic       w_frame;
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  logic       w_upper_zero;
  logic       w_lz_blank;
  logic       w_blink_blank;
  logic       w_blank;

  assign w_tick  = (r_presc == PW'(SCAN_DIV - 1));
  assign w_frame = w_tick && (r_idx == IW'(N_DIGITS - 1));
  assign w_nib   = 4'(r_active >> {r_idx, 2'b00});

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((k >= int'(r_idx)) && (r_active[k*4 +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
  end

  assign w_lz_blank = (LZB != 0) && (r_idx != '0) && w_upper_zero;

`ifdef SEG_BLINK_EN
  localparam int FW = $clog2(BLINK_DIV + 1);
  logic [FW-1:0] r_fcnt;
  logic          r_blink_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt      <= '0;
      r_blink_off <= 1'b0;
    end else if (w_frame) begin
      if (r_fcnt == FW'(BLINK_DIV - 1)) begin
        r_fcnt      <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  assign w_blink_blank = r_blink_off && blink_mask_i[r_idx];
`else
  assign w_blink_blank = 1'b0;
`endif

  assign w_blank = blank_i || w_lz_blank || w_blink_blank;

  always_comb begin
    case (w_nib)
      4'h0:    w_seg = 7'b0000001;
      4'h1:    w_seg = 7'b1001111;
      4'h2:    w_seg = 7'b0010010;
      4'h3:    w_seg = 7'b0000110;
      4'h4:    w_seg = 7'b1001100;
      4'h5:    w_seg = 7'b0100100;
      4'h6:    w_seg = 7'b0100000;
      4'h7:    w_seg = 7'b0001111;
      4'h8:    w_seg = 7'b0000000;
      4'h9:    w_seg = 7'b0001100;
      4'hA:    w_seg = 7'b0001000;
      4'hB:    w_seg = 7'b1100000;
      4'hC:    w_seg = 7'b0110001;
      4'hD:    w_seg = 7'b1000010;
      4'hE:    w_seg = 7'b0110000;
      default: w_seg = 7'b0111000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_idx <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  // Active only changes on the frame edge, so every frame shows one coherent value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= '0;
      r_hold    <= '0;
      pending_o <= 1'b0;
    end else if (load_i && w_frame) begin
      r_active  <= value_i;
      pending_o <= 1'b0;
    end else if (load_i) begin
      r_hold    <= value_i;
      pending_o <= 1'b1;
    end else if (w_frame && pending_o) begin
      r_active  <= r_hold;
      pending_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_o   <= '1;
      dig_o   <= '1;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= w_blank ? 7'h7F : w_seg;
      dig_o   <= ~(N_DIGITS'(1) << r_idx);
      frame_o <= w_frame;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench: directed and random load/blank stimulus against a cycle-count model.
module tb_seven_segment_scan;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 2;
  localparam int FR = N * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  mask = '0;
  logic [6:0]  seg, seg_l;
  logic [3:0]  dig, dig_l;
  logic        frame, frame_l, pend, pend_l;

  int          checks = 0;
  int          errors = 0;
  int          c = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_hold = '0;
  logic        m_pend = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .LZB(0), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .value_i(value), .load_i(load), .blank_i(blank),
    .seg_o(seg), .dig_o(dig), .frame_o(frame), .pending_o(pend)
`ifdef SEG_BLINK_EN
    , .blink_mask_i(mask)
`endif
  );

  seven_segment_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .LZB(1), .BLINK_DIV(BD)) dut_lzb (
    .clk(clk), .rst(rst), .value_i(value), .load_i(load), .blank_i(blank),
    .seg_o(seg_l), .dig_o(dig_l), .frame_o(frame_l), .pending_o(pend_l)
`ifdef SEG_BLINK_EN
    , .blink_mask_i(mask)
`endif
  );

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, predict outputs from the cycle count since reset, compare.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic bl);
    int          idx;
    logic        bound, off;
    logic [15:0] upper;
    logic [6:0]  es, esl;
    logic [3:0]  ed;
    load = ld; value = v; blank = bl;
    @(posedge clk);
    idx   = (c / SD) % N;
    bound = ((c % FR) == FR - 1);
    off   = 1'b0;
`ifdef SEG_BLINK_EN
    off = ((((c / FR) / BD) % 2) == 1) && mask[idx];
`endif
    upper = m_act >> (4 * idx);
    es    = (bl || off) ? 7'h7F : dec(upper[3:0]);
    esl   = (bl || off || (idx != 0 && upper == 16'h0)) ? 7'h7F : dec(upper[3:0]);
    ed    = ~(4'b0001 << idx);
    if (ld && bound) begin
      m_act = v; m_pend = 1'b0;
    end else if (ld) begin
      m_hold = v; m_pend = 1'b1;
    end else if (bound && m_pend) begin
      m_act = m_hold; m_pend = 1'b0;
    end
    c++;
    #1;
    chk("seg", {9'h0, seg}, {9'h0, es});
    chk("seg_lzb", {9'h0, seg_l}, {9'h0, esl});
    chk("dig", {12'h0, dig}, {12'h0, ed});
    chk("frame", {15'h0, frame}, {15'h0, bound});
    chk("pending", {15'h0, pend}, {15'h0, m_pend});
  endtask

  task automatic do_reset();
    load = 1'b0; blank = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dig", {12'h0, dig}, 16'h000F);
    chk("rst_frame", {15'h0, frame}, 16'h0);
    chk("rst_pending", {15'h0, pend}, 16'h0);
    chk("rst_pending_lzb", {15'h0, pend_l}, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_seg", {9'h0, seg}, 16'h007F);
    chk("rst_hold_dig", {12'h0, dig}, 16'h000F);
    @(negedge clk);
    rst = 1'b0;
    c = 0; m_act = '0; m_hold = '0; m_pend = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    repeat (20) cycle(1'b0, 16'($urandom), 1'b0);
    cycle(1'b1, 16'h1234, 1'b0);
    repeat (40) cycle(1'b0, 16'($urandom), 1'b0);

    cycle(1'b1, 16'hAAAA, 1'b0);
    repeat (3) cycle(1'b0, 16'($urandom), 1'b0);
    cycle(1'b1, 16'h00F0, 1'b0);
    repeat (40) cycle(1'b0, 16'($urandom), 1'b0);

    while ((c % FR) != FR - 1) cycle(1'b0, 16'($urandom), 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0);
    repeat (36) cycle(1'b0, 16'($urandom), 1'b0);

    cycle(1'b1, 16'h0050, 1'b0);
    repeat (40) cycle(1'b0, 16'($urandom), 1'b0);
    cycle(1'b1, 16'h0000, 1'b0);
    repeat (40) cycle(1'b0, 16'($urandom), 1'b0);

    cycle(1'b1, 16'h1234, 1'b0);
    repeat (34) cycle(1'b0, 16'($urandom), 1'b0);
    repeat (20) cycle(1'b0, 16'($urandom), 1'b1);
    repeat (20) cycle(1'b0, 16'($urandom), 1'b0);

    mask = 4'b0001;
    repeat (80) cycle(1'b0, 16'($urandom), 1'b0);

    for (int i = 0; i < 400; i++) begin
      mask = 4'($urandom);
      cycle(($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 9) == 0));
    end

    mask = 4'b0000;
    while ((c % FR) != 5) cycle(1'b0, 16'($urandom), 1'b0);
    cycle(1'b1, 16'h5678, 1'b0);
    repeat (3) cycle(1'b0, 16'($urandom), 1'b0);
    #2;
    do_reset();
    repeat (40) cycle(1'b0, 16'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
